// File: rtl/block_renderer.sv
// block_renderer
//   Consumer end of the game-logic position interface. On each draw request
//   the block is erased at its previous column, then redrawn at its new
//   column. The renderer emits one pixel write per cycle to the VGA adapter.
//
//   Optional feature macro: BLOCK_RENDER_CLIP_EN
//     defined   - pixels falling outside SCREEN_W x SCREEN_H get plot=0 for
//                 their cycle; sweep length and timing are unchanged
//     undefined - no bounds check; coordinates wrap modulo 2^8 / 2^7
//
//   Ports
//     clk         in   system clock, rising edge
//     resetn      in   asynchronous active-low reset
//     draw_req    in   1-cycle request, sampled only while idle
//     x           in   new block left-edge column
//     prev_x      in   previous block left-edge column (erase target)
//     y           in   block top row
//     colour      in   block colour for the draw pass
//     vga_x       out  pixel column
//     vga_y       out  pixel row
//     vga_colour  out  pixel colour
//     plot        out  pixel write strobe
//     busy        out  high whenever not idle
//     done        out  1-cycle completion pulse
//
//   state | meaning
//   IDLE  | waiting for draw_req; outputs hold, plot=0
//   ERASE | sweeping BLOCK_W*BLOCK_H pixels at prev_x in BG_COLOUR
//   DRAW  | sweeping BLOCK_W*BLOCK_H pixels at x in the latched colour
//   DONE  | plot=0, done=1 for one cycle, then back to IDLE
module block_renderer #(
    parameter int         BLOCK_W   = 16,
    parameter int         BLOCK_H   = 4,
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       draw_req,
    input  logic [7:0] x,
    input  logic [7:0] prev_x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

`ifdef BLOCK_RENDER_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    localparam int CXW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int CYW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam logic [CXW-1:0] CX_LAST = CXW'(BLOCK_W - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(BLOCK_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [CXW-1:0] cx_q;
    logic [CYW-1:0] cy_q;
    logic [7:0]     x_q;
    logic [7:0]     prev_x_q;
    logic [6:0]     y_q;
    logic [2:0]     colour_q;

    // cx_q/cy_q index the pixel currently on the outputs, so the pixel for
    // the next cycle is computed here and registered on the same edge that
    // advances the counters. This gives the first plot the cycle right
    // after the request edge.
    logic           last_px;
    logic [CXW-1:0] step_cx;
    logic [CYW-1:0] step_cy;
    logic [CXW-1:0] cx_d;
    logic [CYW-1:0] cy_d;
    logic [7:0]     base_x;
    logic [6:0]     base_y;
    logic [8:0]     sum_x;
    logic [7:0]     sum_y;
    logic           px_vis;

    always_comb begin
        last_px = (cx_q == CX_LAST) && (cy_q == CY_LAST);
        if (cx_q == CX_LAST) begin
            step_cx = '0;
            step_cy = cy_q + CYW'(1);
        end else begin
            step_cx = cx_q + CXW'(1);
            step_cy = cy_q;
        end

        cx_d   = '0;
        cy_d   = '0;
        base_x = x_q;
        base_y = y_q;
        case (state_q)
            IDLE: begin
                base_x = prev_x;
                base_y = y;
            end
            ERASE: begin
                if (!last_px) begin
                    base_x = prev_x_q;
                    cx_d   = step_cx;
                    cy_d   = step_cy;
                end
            end
            DRAW: begin
                cx_d = step_cx;
                cy_d = step_cy;
            end
            default: ;
        endcase

        // One bit wider than the adapter bus so off-screen pixels are
        // visible to the bounds check before they wrap.
        sum_x  = {1'b0, base_x} + 9'(cx_d);
        sum_y  = {1'b0, base_y} + 8'(cy_d);
        px_vis = !CLIP_ON || ((sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H)));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            x_q        <= '0;
            prev_x_q   <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (draw_req) begin
                        x_q        <= x;
                        prev_x_q   <= prev_x;
                        y_q        <= y;
                        colour_q   <= colour;
                        cx_q       <= '0;
                        cy_q       <= '0;
                        vga_x      <= sum_x[7:0];
                        vga_y      <= sum_y[6:0];
                        vga_colour <= BG_COLOUR;
                        plot       <= px_vis;
                        busy       <= 1'b1;
                        state_q    <= ERASE;
                    end
                end
                ERASE: begin
                    cx_q  <= cx_d;
                    cy_q  <= cy_d;
                    vga_x <= sum_x[7:0];
                    vga_y <= sum_y[6:0];
                    plot  <= px_vis;
                    if (last_px) begin
                        vga_colour <= colour_q;
                        state_q    <= DRAW;
                    end else begin
                        vga_colour <= BG_COLOUR;
                    end
                end
                DRAW: begin
                    if (last_px) begin
                        cx_q    <= '0;
                        cy_q    <= '0;
                        plot    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cx_q  <= cx_d;
                        cy_q  <= cy_d;
                        vga_x <= sum_x[7:0];
                        vga_y <= sum_y[6:0];
                        plot  <= px_vis;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_renderer.sv
module tb_block_renderer;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int WH = W * H;
    localparam int SW = 160;
    localparam int SH = 120;
    localparam int BG = 0;

    logic       clk;
    logic       resetn;
    logic       draw_req;
    logic [7:0] x;
    logic [7:0] prev_x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    block_renderer dut (
        .clk        (clk),
        .resetn     (resetn),
        .draw_req   (draw_req),
        .x          (x),
        .prev_x     (prev_x),
        .y          (y),
        .colour     (colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit visible(input int col, input int row);
`ifdef BLOCK_RENDER_CLIP_EN
        return (col < SW) && (row < SH);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".plot"}, int'(plot), 0);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".done"}, int'(done), 0);
    endtask

    // Called at a negedge while the DUT is idle. Drives a request, then checks
    // every pixel of both passes, the done cycle, and the return to idle.
    // With noise set, inputs are scrambled after the request and stray
    // requests are issued at N+5 and in the done cycle.
    task automatic run_req(input int nx, input int npx, input int ny, input int ncol,
                           input bit noise);
        int base, cx, cy, col, row, ecol;
        x        = 8'(nx);
        prev_x   = 8'(npx);
        y        = 7'(ny);
        colour   = 3'(ncol);
        draw_req = 1'b1;
        for (int k = 0; k < 2 * WH; k++) begin
            @(negedge clk);
            draw_req = 1'b0;
            if (noise) begin
                x      = 8'($urandom);
                prev_x = 8'($urandom);
                y      = 7'($urandom);
                colour = 3'($urandom);
                if (k == 4) draw_req = 1'b1;
            end
            base = (k < WH) ? npx : nx;
            ecol = (k < WH) ? BG : ncol;
            cx   = (k % WH) % W;
            cy   = (k % WH) / W;
            col  = base + cx;
            row  = ny + cy;
            chk("sweep.busy", int'(busy), 1);
            chk("sweep.done", int'(done), 0);
            chk("sweep.plot", int'(plot), int'(visible(col, row)));
            if (visible(col, row)) begin
                chk("sweep.x", int'(vga_x), col % 256);
                chk("sweep.y", int'(vga_y), row % 128);
                chk("sweep.colour", int'(vga_colour), ecol);
            end
        end
        @(negedge clk);
        draw_req = 1'b0;
        chk("done.done", int'(done), 1);
        chk("done.plot", int'(plot), 0);
        chk("done.busy", int'(busy), 1);
        chk("done.x_hold", int'(vga_x), (nx + W - 1) % 256);
        chk("done.y_hold", int'(vga_y), (ny + H - 1) % 128);
        chk("done.colour_hold", int'(vga_colour), ncol);
        if (noise) draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        check_idle("post");
    endtask

    initial begin
        resetn   = 1'b0;
        draw_req = 1'b0;
        x        = '0;
        prev_x   = '0;
        y        = '0;
        colour   = '0;
        #12;
        chk("rst.x", int'(vga_x), 0);
        chk("rst.y", int'(vga_y), 0);
        chk("rst.colour", int'(vga_colour), 0);
        check_idle("rst");

        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle.plot", int'(plot), 0);
            chk("idle.busy", int'(busy), 0);
        end

        // Nominal request with stray requests and input churn; the
        // following request lands in cycle N+130.
        run_req(40, 32, 100, 4, 1'b1);
        run_req(60, 40, 10, 2, 1'b0);

        // Reset in the middle of the draw pass.
        x        = 8'd20;
        prev_x   = 8'd0;
        y        = 7'd5;
        colour   = 3'd7;
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        repeat (69) @(negedge clk);
        chk("abort.busy_before", int'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("abort.plot", int'(plot), 0);
        chk("abort.busy", int'(busy), 0);
        chk("abort.x", int'(vga_x), 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("abort.idle");
        end
        run_req(20, 0, 5, 7, 1'b0);

        // Right edge and bottom edge.
        run_req(150, 150, 50, 5, 1'b0);
        run_req(10, 12, 126, 3, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_req(int'($urandom_range(255)), int'($urandom_range(255)),
                    int'($urandom_range(127)), int'($urandom_range(7)), r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
